// File: rtl/rx_lane_merge.sv
// Four-lane receive merger: each phy byte lane feeds a small FIFO, and a round-robin
// arbiter drains the FIFOs into one registered ready/valid byte stream tagged with its lane.
module rx_lane_merge #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        fifo_full,
    output logic [3:0]        fifo_empty,
    output logic [3:0]        overflow
);

    logic [DATA_W-1:0] lane_data [4];
    logic [3:0]        lane_valid;

    logic [DATA_W-1:0] mem_q [4][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [4];
    logic [PTR_W-1:0]  wr_ptr_d [4];
    logic [PTR_W-1:0]  rd_ptr_q [4];
    logic [PTR_W-1:0]  rd_ptr_d [4];
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];

    logic [3:0]        full;
    logic [3:0]        empty;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic [3:0]        ovf_q;
    logic [3:0]        ovf_d;

    logic [1:0]        last_grant_q;
    logic [1:0]        last_grant_d;
    logic [1:0]        grant;
    logic [1:0]        arb_idx;
    logic              grant_vld;
    logic              load_en;

    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [1:0]        out_lane_q;
    logic [1:0]        out_lane_d;
    logic              out_valid_q;
    logic              out_valid_d;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_data[2] = in2;
    assign lane_data[3] = in3;
    assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};

    always_comb begin
        full  = '0;
        empty = '0;
        for (int n = 0; n < 4; n++) begin
            full[n]  = (cnt_q[n] == CNT_W'(DEPTH));
            empty[n] = (cnt_q[n] == '0);
        end
    end

    // The output register only advances when it is empty or being consumed.
    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        arb_idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            arb_idx = last_grant_q + 2'(k);
            if (!grant_vld && !empty[arb_idx]) begin
                grant     = arb_idx;
                grant_vld = 1'b1;
            end
        end
    end

    assign pop = (load_en && grant_vld) ? (4'b0001 << grant) : 4'b0000;

    // A full lane still accepts a byte when it is popped in the same cycle.
    always_comb begin
        push  = '0;
        ovf_d = ovf_q;
        for (int n = 0; n < 4; n++) begin
            push[n] = lane_valid[n] && (!full[n] || pop[n]);
            if (lane_valid[n] && full[n] && !pop[n]) begin
                ovf_d[n] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            wr_ptr_d[n] = wr_ptr_q[n];
            rd_ptr_d[n] = rd_ptr_q[n];
            cnt_d[n]    = cnt_q[n];
            if (push[n]) begin
                wr_ptr_d[n] = wr_ptr_q[n] + PTR_W'(1);
            end
            if (pop[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(1);
            end
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CNT_W'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - CNT_W'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_comb begin
        out_data_d   = out_data_q;
        out_lane_d   = out_lane_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d   = mem_q[grant][rd_ptr_q[grant]];
                out_lane_d   = grant;
                last_grant_d = grant;
            end
        end
    end

    // Storage needs no reset: pointers and counts define which entries are live.
    always_ff @(posedge clk_32f) begin
        for (int n = 0; n < 4; n++) begin
            if (push[n]) begin
                mem_q[n][wr_ptr_q[n]] <= lane_data[n];
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= '0;
                rd_ptr_q[n] <= '0;
                cnt_q[n]    <= '0;
            end
            ovf_q        <= '0;
            last_grant_q <= 2'd3;
            out_data_q   <= '0;
            out_lane_q   <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                wr_ptr_q[n] <= wr_ptr_d[n];
                rd_ptr_q[n] <= rd_ptr_d[n];
                cnt_q[n]    <= cnt_d[n];
            end
            ovf_q        <= ovf_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_lane_q   <= out_lane_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_lane   = out_lane_q;
    assign out_valid  = out_valid_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_rx_lane_merge.sv
// Directed bench for rx_lane_merge: a per-cycle vector table plus hand-written
// sequences for reset, full-lane push/pop and saturated fairness.
module tb_rx_lane_merge;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic       valid_in0 = 1'b0, valid_in1 = 1'b0, valid_in2 = 1'b0, valid_in3 = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] out_lane;
    logic       out_valid;
    logic [3:0] fifo_full;
    logic [3:0] fifo_empty;
    logic [3:0] overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        logic [3:0] v;
        logic [7:0] d0, d1, d2, d3;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_lane;
        logic [3:0] e_full;
        logic [3:0] e_empty;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t tbl[$];

    rx_lane_merge #(.DATA_W(8), .DEPTH(4)) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .valid_in0  (valid_in0),
        .valid_in1  (valid_in1),
        .valid_in2  (valid_in2),
        .valid_in3  (valid_in3),
        .out_data   (out_data),
        .out_lane   (out_lane),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic step();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input logic rdy);
        {valid_in3, valid_in2, valid_in1, valid_in0} = v;
        in0 = d0;
        in1 = d1;
        in2 = d2;
        in3 = d3;
        out_ready = rdy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3, input logic rdy,
                       input logic ev, input logic [7:0] ed, input logic [1:0] el,
                       input logic [3:0] ef, input logic [3:0] ee, input logic [3:0] eo);
        vec_t r;
        r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3; r.rdy = rdy;
        r.e_valid = ev; r.e_data = ed; r.e_lane = el;
        r.e_full = ef; r.e_empty = ee; r.e_ovf = eo;
        tbl.push_back(r);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " fifo_empty"}, 32'(fifo_empty), 32'hF);
        chk({tag, " fifo_full"}, 32'(fifo_full), 32'h0);
        chk({tag, " overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        // Reset held with random inputs: everything at its reset value.
        for (int i = 0; i < 4; i++) begin
            drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 1)));
            step();
            chk_idle($sformatf("reset%0d", i));
            chk($sformatf("reset%0d out_data", i), 32'(out_data), 32'h0);
            chk($sformatf("reset%0d out_lane", i), 32'(out_lane), 32'h0);
        end
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
        reset_L = 1'b1;
        step();
        chk_idle("post_reset");

        // Round-robin from reset, then single byte on lane 2, then lane-1 backpressure/overflow.
        add(4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 1, 0, 8'h00, 0, 4'h0, 4'h0, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h10, 0, 4'h0, 4'h1, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h11, 1, 4'h0, 4'h3, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h12, 2, 4'h0, 4'h7, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h13, 3, 4'h0, 4'hF, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 4'h0, 4'hF, 4'h0);
        add(4'h4, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 0, 8'h00, 0, 4'h0, 4'hB, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'hA5, 2, 4'h0, 4'hF, 4'h0);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 4'h0, 4'hF, 4'h0);
        add(4'h2, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 8'h00, 0, 4'h0, 4'hD, 4'h0);
        add(4'h2, 8'h00, 8'h02, 8'h00, 8'h00, 0, 1, 8'h01, 1, 4'h0, 4'hD, 4'h0);
        add(4'h2, 8'h00, 8'h03, 8'h00, 8'h00, 0, 1, 8'h01, 1, 4'h0, 4'hD, 4'h0);
        add(4'h2, 8'h00, 8'h04, 8'h00, 8'h00, 0, 1, 8'h01, 1, 4'h0, 4'hD, 4'h0);
        add(4'h2, 8'h00, 8'h05, 8'h00, 8'h00, 0, 1, 8'h01, 1, 4'h2, 4'hD, 4'h0);
        add(4'h2, 8'h00, 8'h06, 8'h00, 8'h00, 0, 1, 8'h01, 1, 4'h2, 4'hD, 4'h2);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h02, 1, 4'h0, 4'hD, 4'h2);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h03, 1, 4'h0, 4'hD, 4'h2);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h04, 1, 4'h0, 4'hD, 4'h2);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 8'h05, 1, 4'h0, 4'hF, 4'h2);
        add(4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 4'h0, 4'hF, 4'h2);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].rdy);
            step();
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_data));
                chk($sformatf("row%0d out_lane", i), 32'(out_lane), 32'(tbl[i].e_lane));
            end
            chk($sformatf("row%0d fifo_full", i), 32'(fifo_full), 32'(tbl[i].e_full));
            chk($sformatf("row%0d fifo_empty", i), 32'(fifo_empty), 32'(tbl[i].e_empty));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
        end

        // Mid-burst reset takes effect without a clock edge.
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 8'h20, 8'h21, 8'h22, 8'h23, 1'b0);
            step();
        end
        #2;
        reset_L = 1'b0;
        #1;
        chk_idle("async_reset");
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0);
        step();
        reset_L = 1'b1;
        step();
        chk_idle("async_release");

        // Lane 3 full; push EE in the same cycle lane 3 is popped.
        for (int i = 0; i < 5; i++) begin
            drive(4'h8, 8'h0, 8'h0, 8'h0, 8'(8'h30 + i), 1'b0);
            step();
        end
        chk("full3 fifo_full", 32'(fifo_full), 32'h8);
        chk("full3 held data", 32'({out_valid, out_lane, out_data}), 32'({1'b1, 2'd3, 8'h30}));
        drive(4'h8, 8'h0, 8'h0, 8'h0, 8'hEE, 1'b1);
        step();
        chk("pushpop out", 32'({out_valid, out_lane, out_data}), 32'({1'b1, 2'd3, 8'h31}));
        chk("pushpop fifo_full", 32'(fifo_full), 32'h8);
        chk("pushpop overflow", 32'(overflow), 32'h0);
        exp_q.push_back({2'd3, 8'h32});
        exp_q.push_back({2'd3, 8'h33});
        exp_q.push_back({2'd3, 8'h34});
        exp_q.push_back({2'd3, 8'hEE});
        drive(4'h0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b1);
        while (exp_q.size() > 0) begin
            logic [9:0] e;
            e = exp_q.pop_front();
            step();
            chk("drain3 out_valid", 32'(out_valid), 32'd1);
            chk("drain3 lane/data", 32'({out_lane, out_data}), 32'(e));
        end
        step();
        chk_idle("drain3 idle");

        // Saturated fairness: lanes 0..3 granted in strict rotation.
        for (int i = 0; i < 40; i++) begin
            drive(4'hF, {2'd0, 6'(i)}, {2'd1, 6'(i)}, {2'd2, 6'(i)}, {2'd3, 6'(i)}, 1'b1);
            step();
            if (i == 0) begin
                chk("fair first out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk($sformatf("fair%0d out_valid", i), 32'(out_valid), 32'd1);
                chk($sformatf("fair%0d out_lane", i), 32'(out_lane), 32'((i - 1) % 4));
                chk($sformatf("fair%0d data tag", i), 32'(out_data[7:6]), 32'((i - 1) % 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
